rst_clken_gen: RTL and testbench

//  Parametrised reset sequencer, multi-channel clock-enable divider and test-pattern source.

---
 rtl/rst_clken_gen.sv | 124 ++++++++++++
 tb/tb_rst_clken_gen.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/rst_clken_gen.sv
// rst_clken_gen: reset stretcher, phase-aligned clock-enable divider and test-pattern source.
//   clk, res          : system clock, synchronous active-high board reset
//   div_cfg, div_load : per-channel divisors and a load strobe that restarts all channels together
//   gen_en, fifo_full : pattern enable and downstream back-pressure
//   res_o, res_n_o    : stretched internal reset pair
//   ce, tgl           : per-channel enable pulses and matching toggle waves
//   data, wr_en       : test word and its write strobe
//   stall             : sticky flag, a write slot found the FIFO full
module rst_clken_gen #(
    parameter int RST_CYCLES = 4,
    parameter int NUM_CH     = 4,
    parameter int DIV_W      = 8,
    parameter int DEF_DIV    = 1,
    parameter int DATA_W     = 8
) (
    input  logic                      clk,
    input  logic                      res,
    input  logic [NUM_CH*DIV_W-1:0]   div_cfg,
    input  logic                      div_load,
    input  logic                      gen_en,
    input  logic                      fifo_full,
    output logic                      res_o,
    output logic                      res_n_o,
    output logic [NUM_CH-1:0]         ce,
    output logic [NUM_CH-1:0]         tgl,
    output logic [DATA_W-1:0]         data,
    output logic                      wr_en,
    output logic                      stall
);
    localparam int CW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [NUM_CH*DIV_W-1:0] DIV_RST = {NUM_CH{DIV_W'(DEF_DIV)}};
    typedef enum logic {RESET, RUN} state_t;
    state_t                    state_q = RESET, state_d;
    logic [CW-1:0]             rst_cnt_q = '0, rst_cnt_d;
    logic [NUM_CH*DIV_W-1:0]   div_q = DIV_RST, div_d;
    logic [NUM_CH*DIV_W-1:0]   cnt_q = '0, cnt_d;
    logic [NUM_CH-1:0]         ce_q = '0, ce_d;
    logic [NUM_CH-1:0]         tgl_q = '0, tgl_d;
    logic                      res_o_q = 1'b1, res_o_d;
    logic                      res_n_o_q = 1'b0, res_n_o_d;
    logic [DATA_W-1:0]         data_q = '0, data_d;
    logic [DATA_W-1:0]         pat_q = '0, pat_d;
    logic                      wr_en_q = 1'b0, wr_en_d;
    logic                      stall_q = 1'b0, stall_d;
    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        ce_d      = '0;
        tgl_d     = tgl_q;
        res_o_d   = res_o_q;
        res_n_o_d = res_n_o_q;
        data_d    = data_q;
        pat_d     = pat_q;
        wr_en_d   = 1'b0;
        stall_d   = stall_q;
        if (res) begin
            state_d   = RESET;
            rst_cnt_d = '0;
            div_d     = DIV_RST;
            cnt_d     = '0;
            tgl_d     = '0;
            res_o_d   = 1'b1;
            res_n_o_d = 1'b0;
            data_d    = '0;
            pat_d     = '0;
            stall_d   = 1'b0;
        end else begin
            if (state_q == RESET) begin
                if (rst_cnt_q == CW'(RST_CYCLES - 1)) begin
                    state_d   = RUN;
                    rst_cnt_d = '0;
                    res_o_d   = 1'b0;
                    res_n_o_d = 1'b1;
                end else begin
                    rst_cnt_d = rst_cnt_q + CW'(1);
                end
            end
            // A load restarts every channel at count 0 and swallows this edge's enables.
            if (div_load) begin
                div_d = div_cfg;
                cnt_d = '0;
            end else if (state_q == RUN) begin
                for (int k = 0; k < NUM_CH; k++) begin
                    ce_d[k] = cnt_q[k*DIV_W +: DIV_W] == div_q[k*DIV_W +: DIV_W];
                    cnt_d[k*DIV_W +: DIV_W] = ce_d[k] ? '0 : cnt_q[k*DIV_W +: DIV_W] + DIV_W'(1);
                end
                tgl_d = tgl_q ^ ce_d;
                // Write slot: the edge that raises ce[0]; a full FIFO keeps the word for the next slot.
                if (ce_d[0] && gen_en) begin
                    if (fifo_full) begin
                        stall_d = 1'b1;
                    end else begin
                        wr_en_d = 1'b1;
                        data_d  = pat_q;
                        pat_d   = pat_q + DATA_W'(1);
                    end
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        state_q   <= state_d;
        rst_cnt_q <= rst_cnt_d;
        div_q     <= div_d;
        cnt_q     <= cnt_d;
        ce_q      <= ce_d;
        tgl_q     <= tgl_d;
        res_o_q   <= res_o_d;
        res_n_o_q <= res_n_o_d;
        data_q    <= data_d;
        pat_q     <= pat_d;
        wr_en_q   <= wr_en_d;
        stall_q   <= stall_d;
    end
    assign res_o   = res_o_q;
    assign res_n_o = res_n_o_q;
    assign ce      = ce_q;
    assign tgl     = tgl_q;
    assign data    = data_q;
    assign wr_en   = wr_en_q;
    assign stall   = stall_q;
endmodule

// File: tb/tb_rst_clken_gen.sv
// tb_rst_clken_gen: scenario tasks for rst_clken_gen with a write-data scoreboard.
module tb_rst_clken_gen;
    logic        clk = 1'b0;
    logic        res = 1'b1;
    logic [31:0] div_cfg = '0;
    logic        div_load = 1'b0;
    logic        gen_en = 1'b0;
    logic        fifo_full = 1'b0;
    logic        res_o, res_n_o, wr_en, stall;
    logic [3:0]  ce, tgl;
    logic [7:0]  data;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  sb_q[$];
    logic [7:0]  exp_pat = '0;
    logic [3:0]  exp_tgl = '0;
    rst_clken_gen dut (
        .clk(clk), .res(res), .div_cfg(div_cfg), .div_load(div_load),
        .gen_en(gen_en), .fifo_full(fifo_full), .res_o(res_o), .res_n_o(res_n_o),
        .ce(ce), .tgl(tgl), .data(data), .wr_en(wr_en), .stall(stall)
    );
    always #5 clk = ~clk;
    // Every observed write must match the oldest word the stimulus expects.
    always @(negedge clk) begin
        if (wr_en === 1'b1) begin
            n_chk++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected_write: got data=%0d, expected no write", data);
            end else begin
                logic [7:0] e;
                e = sb_q.pop_front();
                if (data !== e) begin
                    n_fail++;
                    $display("FAIL sb_data: got %0d, expected %0d", data, e);
                end
            end
        end
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic test_reset;
        res = 1'b1;
        repeat (3) tick();
        n_chk++;
        if ({res_o, res_n_o, ce, tgl, data, wr_en, stall} !== {1'b1, 1'b0, 4'h0, 4'h0, 8'h00, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_values: got res_o=%b res_n_o=%b ce=%h tgl=%h data=%0d wr_en=%b stall=%b, expected 1 0 0 0 0 0 0",
                     res_o, res_n_o, ce, tgl, data, wr_en, stall);
        end
        res = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_chk++;
            if ({res_o, res_n_o, ce} !== {(i < 4), (i >= 4), 4'h0}) begin
                n_fail++;
                $display("FAIL reset_stretch[%0d]: got res_o=%b res_n_o=%b ce=%h, expected %b %b 0",
                         i, res_o, res_n_o, ce, (i < 4), (i >= 4));
            end
        end
    endtask
    task automatic test_div_default;
        exp_tgl = '0;
        for (int i = 1; i <= 8; i++) begin
            logic [3:0] e;
            tick();
            e = (i % 2 == 0) ? 4'hf : 4'h0;
            exp_tgl ^= e;
            n_chk++;
            if (ce !== e || tgl !== exp_tgl) begin
                n_fail++;
                $display("FAIL div_default[%0d]: got ce=%h tgl=%h, expected ce=%h tgl=%h", i, ce, tgl, e, exp_tgl);
            end
        end
    endtask
    task automatic test_div_load;
        int d[4] = '{0, 3, 7, 255};
        tick();
        div_cfg = {8'd255, 8'd7, 8'd3, 8'd0};
        div_load = 1'b1;
        tick();
        div_load = 1'b0;
        n_chk++;
        if (ce !== 4'h0 || tgl !== exp_tgl ^ (tgl ^ exp_tgl)) begin
            n_fail++;
            $display("FAIL div_load_edge: got ce=%h, expected 0", ce);
        end
        exp_tgl = tgl;
        for (int j = 1; j <= 520; j++) begin
            logic [3:0] e;
            tick();
            for (int k = 0; k < 4; k++) e[k] = (j % (d[k] + 1)) == 0;
            exp_tgl ^= e;
            n_chk++;
            if (ce !== e || tgl !== exp_tgl) begin
                n_fail++;
                $display("FAIL div_load[%0d]: got ce=%h tgl=%h, expected ce=%h tgl=%h", j, ce, tgl, e, exp_tgl);
            end
        end
    endtask
    task automatic test_stream;
        gen_en = 1'b1;
        fifo_full = 1'b0;
        for (int i = 0; i < 300; i++) begin
            sb_q.push_back(exp_pat);
            exp_pat++;
            tick();
        end
        gen_en = 1'b0;
        tick();
        n_chk++;
        if (sb_q.size() != 0 || stall !== 1'b0) begin
            n_fail++;
            $display("FAIL stream_end: got pending=%0d stall=%b, expected 0 0", sb_q.size(), stall);
        end
        tick();
        n_chk++;
        if (wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL gen_off: got wr_en=%b, expected 0", wr_en);
        end
    endtask
    task automatic test_full;
        gen_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            fifo_full = (i >= 10 && i < 15);
            if (!fifo_full) begin
                sb_q.push_back(exp_pat);
                exp_pat++;
            end
            tick();
            if (fifo_full) begin
                n_chk++;
                if (wr_en !== 1'b0 || data !== exp_pat - 8'd1 || stall !== 1'b1) begin
                    n_fail++;
                    $display("FAIL full_slot[%0d]: got wr_en=%b data=%0d stall=%b, expected 0 %0d 1",
                             i, wr_en, data, stall, exp_pat - 8'd1);
                end
            end
        end
        fifo_full = 1'b0;
        n_chk++;
        if (stall !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_sticky: got %b, expected 1", stall);
        end
    endtask
    task automatic test_mid_reset;
        n_chk++;
        if (wr_en !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_wr: got wr_en=%b, expected 1", wr_en);
        end
        res = 1'b1;
        gen_en = 1'b0;
        tick();
        n_chk++;
        if ({wr_en, data, ce, tgl, res_o, res_n_o, stall} !== {1'b0, 8'h00, 4'h0, 4'h0, 1'b1, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: got wr_en=%b data=%0d ce=%h tgl=%h res_o=%b res_n_o=%b stall=%b, expected 0 0 0 0 1 0 0",
                     wr_en, data, ce, tgl, res_o, res_n_o, stall);
        end
        res = 1'b0;
        exp_pat = '0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            n_chk++;
            if ({res_o, res_n_o} !== {(i < 4), (i >= 4)}) begin
                n_fail++;
                $display("FAIL restretch[%0d]: got res_o=%b res_n_o=%b, expected %b %b", i, res_o, res_n_o, (i < 4), (i >= 4));
            end
        end
        test_div_default();
    endtask
    initial begin
        test_reset();
        test_div_default();
        test_div_load();
        test_stream();
        test_full();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
